// File: rtl/sub_top_conv.sv
// 3x3 convolution engine: IFM/weight BRAMs, pixel address generator and 16 int8 MAC PEs.
// Define CONV_RELU_EN to apply ReLU before saturation (output range [0,127]).
module sub_top_conv (
   input  logic        clk,
   input  logic        reset,
   input  logic        we_IFM,
   input  logic        we_weight,
   input  logic [31:0] addr,
   input  logic [31:0] data_in_IFM,
   input  logic [31:0] data_in_Weight_0,
   input  logic [31:0] data_in_Weight_1,
   input  logic [31:0] data_in_Weight_2,
   input  logic [31:0] data_in_Weight_3,
   input  logic [31:0] data_in_Weight_4,
   input  logic [31:0] data_in_Weight_5,
   input  logic [31:0] data_in_Weight_6,
   input  logic [31:0] data_in_Weight_7,
   input  logic [31:0] data_in_Weight_8,
   input  logic [31:0] data_in_Weight_9,
   input  logic [31:0] data_in_Weight_10,
   input  logic [31:0] data_in_Weight_11,
   input  logic [31:0] data_in_Weight_12,
   input  logic [31:0] data_in_Weight_13,
   input  logic [31:0] data_in_Weight_14,
   input  logic [31:0] data_in_Weight_15,
   input  logic        cal_start,
   input  logic [15:0] PE_reset,
   input  logic [15:0] PE_finish,
   output logic [15:0] valid,
   output logic [7:0]  OFM_0,
   output logic [7:0]  OFM_1,
   output logic [7:0]  OFM_2,
   output logic [7:0]  OFM_3,
   output logic [7:0]  OFM_4,
   output logic [7:0]  OFM_5,
   output logic [7:0]  OFM_6,
   output logic [7:0]  OFM_7,
   output logic [7:0]  OFM_8,
   output logic [7:0]  OFM_9,
   output logic [7:0]  OFM_10,
   output logic [7:0]  OFM_11,
   output logic [7:0]  OFM_12,
   output logic [7:0]  OFM_13,
   output logic [7:0]  OFM_14,
   output logic [7:0]  OFM_15,
   output logic [31:0] OFM
);
   localparam int IFM_W     = 58;
   localparam int OFM_W     = 56;
   localparam int NUM_PE    = 16;
   localparam int IFM_DEPTH = 13456;
   localparam int W_DEPTH   = 72;

   logic [31:0] w_in [NUM_PE];
   assign w_in[0]  = data_in_Weight_0;
   assign w_in[1]  = data_in_Weight_1;
   assign w_in[2]  = data_in_Weight_2;
   assign w_in[3]  = data_in_Weight_3;
   assign w_in[4]  = data_in_Weight_4;
   assign w_in[5]  = data_in_Weight_5;
   assign w_in[6]  = data_in_Weight_6;
   assign w_in[7]  = data_in_Weight_7;
   assign w_in[8]  = data_in_Weight_8;
   assign w_in[9]  = data_in_Weight_9;
   assign w_in[10] = data_in_Weight_10;
   assign w_in[11] = data_in_Weight_11;
   assign w_in[12] = data_in_Weight_12;
   assign w_in[13] = data_in_Weight_13;
   assign w_in[14] = data_in_Weight_14;
   assign w_in[15] = data_in_Weight_15;

   // Address generator: cw fastest, then kw, kh, column, row, tile.
   logic [1:0] cw_q, cw_d, kw_q, kw_d, kh_q, kh_d;
   logic [5:0] c_q, c_d, r_q, r_d;
   logic       tile_q, tile_d;

   always_comb begin
      cw_d   = cw_q;
      kw_d   = kw_q;
      kh_d   = kh_q;
      c_d    = c_q;
      r_d    = r_q;
      tile_d = tile_q;
      if (cal_start) begin
         if (cw_q != 2'd3) cw_d = cw_q + 2'd1;
         else begin
            cw_d = '0;
            if (kw_q != 2'd2) kw_d = kw_q + 2'd1;
            else begin
               kw_d = '0;
               if (kh_q != 2'd2) kh_d = kh_q + 2'd1;
               else begin
                  kh_d = '0;
                  if (c_q != 6'(OFM_W - 1)) c_d = c_q + 6'd1;
                  else begin
                     c_d = '0;
                     if (r_q != 6'(OFM_W - 1)) r_d = r_q + 6'd1;
                     else begin
                        r_d    = '0;
                        tile_d = ~tile_q;
                     end
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cw_q   <= '0;
         kw_q   <= '0;
         kh_q   <= '0;
         c_q    <= '0;
         r_q    <= '0;
         tile_q <= 1'b0;
      end else begin
         cw_q   <= cw_d;
         kw_q   <= kw_d;
         kh_q   <= kh_d;
         c_q    <= c_d;
         r_q    <= r_d;
         tile_q <= tile_d;
      end
   end

   logic [13:0] ifm_rd_addr;
   logic [6:0]  w_rd_addr;
   assign ifm_rd_addr = ((14'(r_q) + 14'(kh_q)) * 14'(IFM_W) + 14'(c_q) + 14'(kw_q)) * 14'd4
                        + 14'(cw_q);
   assign w_rd_addr   = 7'(tile_q) * 7'd36 + (7'(kh_q) * 7'd3 + 7'(kw_q)) * 7'd4 + 7'(cw_q);

   // BRAMs: contents survive reset, reads are registered (1-cycle latency).
   logic [31:0] ifm_mem [IFM_DEPTH];
   logic [31:0] w_mem   [NUM_PE][W_DEPTH];
   logic [31:0] ifm_rdata_q;
   logic [31:0] w_rdata_q [NUM_PE];

   always_ff @(posedge clk) begin
      if (we_IFM && (addr < 32'(IFM_DEPTH))) ifm_mem[addr[13:0]] <= data_in_IFM;
      ifm_rdata_q <= ifm_mem[ifm_rd_addr];
   end

   always_ff @(posedge clk) begin
      for (int n = 0; n < NUM_PE; n++) begin
         if (we_weight && (addr < 32'(W_DEPTH))) w_mem[n][addr[6:0]] <= w_in[n];
         w_rdata_q[n] <= w_mem[n][w_rd_addr];
      end
   end

   function automatic logic signed [31:0] sx8(input logic [7:0] b);
      sx8 = $signed({{24{b[7]}}, b});
   endfunction

   function automatic logic [7:0] clamp8(input logic signed [31:0] v);
`ifdef CONV_RELU_EN
      if (v < 32'sd0)        clamp8 = 8'h00;
      else if (v > 32'sd127) clamp8 = 8'h7F;
      else                   clamp8 = v[7:0];
`else
      if (v > 32'sd127)       clamp8 = 8'h7F;
      else if (v < -32'sd128) clamp8 = 8'h80;
      else                    clamp8 = v[7:0];
`endif
   endfunction

   // Operand stage lines the BRAM data up with the host's PE_reset/PE_finish pulses.
   logic [31:0]        op_ifm_q, op_ifm_d;
   logic [31:0]        op_w_q [NUM_PE];
   logic [31:0]        op_w_d [NUM_PE];
   logic signed [31:0] acc_q  [NUM_PE];
   logic signed [31:0] acc_d  [NUM_PE];
   logic [7:0]         ofm_q  [NUM_PE];
   logic [7:0]         ofm_d  [NUM_PE];
   logic [15:0]        valid_q, valid_d;
   logic signed [31:0] prod, sum;

   always_comb begin
      op_ifm_d = ifm_rdata_q;
      valid_d  = '0;
      prod     = '0;
      sum      = '0;
      for (int n = 0; n < NUM_PE; n++) begin
         op_w_d[n] = w_rdata_q[n];
         prod = '0;
         for (int i = 0; i < 4; i++)
            prod = prod + sx8(op_ifm_q[8*i +: 8]) * sx8(op_w_q[n][8*i +: 8]);
         sum       = (PE_reset[n] ? 32'sd0 : acc_q[n]) + prod;
         acc_d[n]  = sum;
         ofm_d[n]  = PE_finish[n] ? clamp8(sum) : ofm_q[n];
         valid_d[n] = PE_finish[n];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_ifm_q <= '0;
         valid_q  <= '0;
         for (int n = 0; n < NUM_PE; n++) begin
            op_w_q[n] <= '0;
            acc_q[n]  <= '0;
            ofm_q[n]  <= '0;
         end
      end else begin
         op_ifm_q <= op_ifm_d;
         valid_q  <= valid_d;
         for (int n = 0; n < NUM_PE; n++) begin
            op_w_q[n] <= op_w_d[n];
            acc_q[n]  <= acc_d[n];
            ofm_q[n]  <= ofm_d[n];
         end
      end
   end

   assign valid  = valid_q;
   assign OFM_0  = ofm_q[0];
   assign OFM_1  = ofm_q[1];
   assign OFM_2  = ofm_q[2];
   assign OFM_3  = ofm_q[3];
   assign OFM_4  = ofm_q[4];
   assign OFM_5  = ofm_q[5];
   assign OFM_6  = ofm_q[6];
   assign OFM_7  = ofm_q[7];
   assign OFM_8  = ofm_q[8];
   assign OFM_9  = ofm_q[9];
   assign OFM_10 = ofm_q[10];
   assign OFM_11 = ofm_q[11];
   assign OFM_12 = ofm_q[12];
   assign OFM_13 = ofm_q[13];
   assign OFM_14 = ofm_q[14];
   assign OFM_15 = ofm_q[15];
   assign OFM    = {ofm_q[3], ofm_q[2], ofm_q[1], ofm_q[0]};
endmodule

// File: tb/tb_sub_top_conv.sv
// Bench for sub_top_conv: vector table of uniform pixels, hand sequences, and a scoreboarded
// 57-pixel run over a random IFM checked against a behavioural convolution model.
module tb_sub_top_conv;
   logic        clk = 1'b0;
   logic        reset;
   logic        we_IFM, we_weight, cal_start;
   logic [31:0] addr, data_in_IFM;
   logic [31:0] w_in [16];
   logic [15:0] PE_reset, PE_finish, valid;
   logic [7:0]  ofm_o [16];
   logic [31:0] OFM;
   logic [127:0] ofm_all;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int valid_seen = 0;
   int pix_idx = 0;
   logic [143:0] exp_q [$];
   logic [127:0] last_exp = '0;

   logic [31:0] ifm_m [13456];
   logic [31:0] w_m [16][72];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb for (int n = 0; n < 16; n++) ofm_all[8*n +: 8] = ofm_o[n];

   sub_top_conv dut (
      .clk(clk), .reset(reset), .we_IFM(we_IFM), .we_weight(we_weight), .addr(addr),
      .data_in_IFM(data_in_IFM),
      .data_in_Weight_0(w_in[0]),   .data_in_Weight_1(w_in[1]),   .data_in_Weight_2(w_in[2]),
      .data_in_Weight_3(w_in[3]),   .data_in_Weight_4(w_in[4]),   .data_in_Weight_5(w_in[5]),
      .data_in_Weight_6(w_in[6]),   .data_in_Weight_7(w_in[7]),   .data_in_Weight_8(w_in[8]),
      .data_in_Weight_9(w_in[9]),   .data_in_Weight_10(w_in[10]), .data_in_Weight_11(w_in[11]),
      .data_in_Weight_12(w_in[12]), .data_in_Weight_13(w_in[13]), .data_in_Weight_14(w_in[14]),
      .data_in_Weight_15(w_in[15]),
      .cal_start(cal_start), .PE_reset(PE_reset), .PE_finish(PE_finish), .valid(valid),
      .OFM_0(ofm_o[0]),   .OFM_1(ofm_o[1]),   .OFM_2(ofm_o[2]),   .OFM_3(ofm_o[3]),
      .OFM_4(ofm_o[4]),   .OFM_5(ofm_o[5]),   .OFM_6(ofm_o[6]),   .OFM_7(ofm_o[7]),
      .OFM_8(ofm_o[8]),   .OFM_9(ofm_o[9]),   .OFM_10(ofm_o[10]), .OFM_11(ofm_o[11]),
      .OFM_12(ofm_o[12]), .OFM_13(ofm_o[13]), .OFM_14(ofm_o[14]), .OFM_15(ofm_o[15]),
      .OFM(OFM)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard: every valid pulse must match the oldest pending result, at the predicted cycle.
   always @(negedge clk) begin
      if (!reset && valid !== 16'h0) begin
         valid_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: valid=%h with no pending result", valid);
         end else begin
            logic [143:0] e;
            e = exp_q.pop_front();
            last_exp = e[127:0];
            check("valid_mask", 128'(valid), 128'h0000_ffff);
            check("ofm_bytes", ofm_all, e[127:0]);
            check("ofm_word", 128'(OFM), 128'(e[31:0]));
            check("valid_cycle", 128'(cyc[15:0]), 128'(e[143:128]));
         end
      end
   end

   function automatic logic [7:0] clamp8(input int v);
`ifdef CONV_RELU_EN
      if (v < 0) return 8'h00;
      if (v > 127) return 8'h7F;
`else
      if (v > 127) return 8'h7F;
      if (v < -128) return 8'h80;
`endif
      return v[7:0];
   endfunction

   // Reference: direct 3x3x16 convolution over pixel-major, channel-minor IFM storage.
   function automatic logic [7:0] model_pix(input int pe, input int idx);
      int tile, r, c, acc, wd, ww;
      logic signed [7:0] a, b;
      tile = idx / 3136;
      r    = (idx % 3136) / 56;
      c    = idx % 56;
      acc  = 0;
      for (int kh = 0; kh < 3; kh++)
         for (int kw = 0; kw < 3; kw++)
            for (int ch = 0; ch < 16; ch++) begin
               wd = ((r + kh) * 58 + (c + kw)) * 4 + ch / 4;
               ww = tile * 36 + (kh * 3 + kw) * 4 + ch / 4;
               a  = ifm_m[wd][31 - 8*(ch % 4) -: 8];
               b  = w_m[pe][ww][31 - 8*(ch % 4) -: 8];
               acc += int'(a) * int'(b);
            end
      return clamp8(acc);
   endfunction

   function automatic logic [7:0] rb();
      case ($urandom_range(0, 2))
         0:       return 8'hFF;
         1:       return 8'h00;
         default: return 8'h01;
      endcase
   endfunction

   task automatic wr_ifm(input logic [31:0] a, input logic [31:0] d);
      we_IFM = 1'b1; addr = a; data_in_IFM = d;
      @(negedge clk);
      we_IFM = 1'b0;
   endtask

   task automatic wr_w(input logic [31:0] a);
      we_weight = 1'b1; addr = a;
      @(negedge clk);
      we_weight = 1'b0;
   endtask

   task automatic reset_dut();
      reset = 1'b1; cal_start = 1'b0; PE_reset = '0; PE_finish = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      pix_idx = 0;
      @(negedge clk);
   endtask

   task automatic load_region(input logic [31:0] iw);
      for (int kh = 0; kh < 3; kh++)
         for (int j = 0; j < 12; j++) wr_ifm(32'(kh * 232 + j), iw);
   endtask

   // Host schedule: cal_start for 36*n edges, PE_reset on the 3rd edge, PE_finish 35 edges later.
   task automatic run_pixels(input int n, input bit use_model, input logic [127:0] fixed);
      logic [127:0] ev;
      bit fin;
      for (int i = 0; i <= 36 * n + 1; i++) begin
         cal_start = (i < 36 * n);
         PE_reset  = (i >= 2 && i < 2 + 36 * n && (i - 2) % 36 == 0) ? '1 : '0;
         fin       = (i >= 37 && (i - 37) % 36 == 0);
         PE_finish = fin ? '1 : '0;
         if (fin) begin
            if (use_model)
               for (int p = 0; p < 16; p++) ev[8*p +: 8] = model_pix(p, pix_idx);
            else
               ev = fixed;
            exp_q.push_back({16'(cyc + 1), ev});
            pix_idx++;
         end
         @(negedge clk);
      end
      PE_reset = '0; PE_finish = '0; cal_start = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
      check("sb_drained", 128'(exp_q.size()), 128'd0);
      repeat (3) @(negedge clk);
      check("ofm_hold", ofm_all, last_exp);
      check("valid_idle", 128'(valid), 128'd0);
   endtask

   typedef struct {
      logic [31:0] ifm_word;
      logic [31:0] w_word;
      logic [7:0]  exp_sat;
      logic [7:0]  exp_relu;
   } vec_t;

   initial begin
      vec_t tbl [8];
      logic [7:0] e8;
      logic [127:0] ev;
      int vs0;

      // Uniform words: result = 36 * (per-word byte dot product).
      tbl[0] = '{32'h01010101, 32'h01010101, 8'h7F, 8'h7F};   //  144
      tbl[1] = '{32'h01010101, 32'hFFFFFFFF, 8'h80, 8'h00};   // -144
      tbl[2] = '{32'h01000000, 32'h02000000, 8'h48, 8'h48};   //   72
      tbl[3] = '{32'hFF000000, 32'h03000000, 8'h94, 8'h00};   // -108
      tbl[4] = '{32'h0000FF01, 32'h0000FF02, 8'h6C, 8'h6C};   //  108
      tbl[5] = '{32'h80808080, 32'h80808080, 8'h7F, 8'h7F};
      tbl[6] = '{32'h7F7F7F7F, 32'h80808080, 8'h80, 8'h00};
      tbl[7] = '{32'h12345678, 32'h00000000, 8'h00, 8'h00};

      reset = 1'b1; we_IFM = 1'b0; we_weight = 1'b0; addr = '0; data_in_IFM = '0;
      cal_start = 1'b0; PE_reset = '0; PE_finish = '0;
      for (int n = 0; n < 16; n++) w_in[n] = '0;

      repeat (3) @(negedge clk);
      check("reset_valid", 128'(valid), 128'd0);
      check("reset_ofm", 128'(OFM), 128'd0);
      check("reset_ofm_all", ofm_all, 128'd0);
      PE_finish = '1;
      @(negedge clk);
      @(negedge clk);
      check("reset_finish_blocked", 128'(valid), 128'd0);
      PE_finish = '0;
      reset = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 8; t++) begin
         reset_dut();
         vs0 = valid_seen;
         load_region(tbl[t].ifm_word);
         for (int n = 0; n < 16; n++) w_in[n] = tbl[t].w_word;
         for (int a = 0; a < 36; a++) wr_w(32'(a));
         check("no_valid_on_load", 128'(valid_seen), 128'(vs0));
`ifdef CONV_RELU_EN
         e8 = tbl[t].exp_relu;
`else
         e8 = tbl[t].exp_sat;
`endif
         run_pixels(1, 1'b0, {16{e8}});
      end

      // Only PE5 has a nonzero weight, on the first word of the kernel.
      reset_dut();
      load_region(32'h03000000);
      for (int a = 0; a < 36; a++) begin
         for (int n = 0; n < 16; n++) w_in[n] = (n == 5 && a == 0) ? 32'h02000000 : 32'h0;
         wr_w(32'(a));
      end
      ev = '0;
      ev[47:40] = 8'h06;
      run_pixels(1, 1'b0, ev);

      // Full random IFM/weights with small values so most results stay inside int8.
      reset_dut();
      vs0 = valid_seen;
      for (int a = 0; a < 13456; a++) begin
         ifm_m[a] = {rb(), rb(), rb(), rb()};
         wr_ifm(32'(a), ifm_m[a]);
      end
      for (int a = 0; a < 72; a++) begin
         for (int n = 0; n < 16; n++) begin
            w_m[n][a] = {rb(), rb(), rb(), rb()};
            w_in[n]   = w_m[n][a];
         end
         wr_w(32'(a));
      end
      // Out-of-range writes must not alias onto low addresses.
      wr_ifm(32'h0000_4000, 32'h7F7F7F7F);
      wr_ifm(32'd13456, 32'h7F7F7F7F);
      for (int n = 0; n < 16; n++) w_in[n] = 32'h7F7F7F7F;
      wr_w(32'd128);
      wr_w(32'd72);
      check("no_valid_full_load", 128'(valid_seen), 128'(vs0));

      // Reset in the middle of a pixel aborts it; the generator restarts at pixel (0,0).
      reset_dut();
      cal_start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         PE_reset = (i == 2) ? '1 : '0;
         @(negedge clk);
      end
      reset = 1'b1; cal_start = 1'b0; PE_reset = '0; PE_finish = '1;
      @(negedge clk);
      check("midreset_valid", 128'(valid), 128'd0);
      check("midreset_ofm", ofm_all, 128'd0);
      reset = 1'b0; PE_finish = '0;
      vs0 = valid_seen;
      repeat (40) @(negedge clk);
      check("midreset_no_valid", 128'(valid_seen), 128'(vs0));
      pix_idx = 0;
      run_pixels(1, 1'b1, '0);

      // 57 back-to-back pixels: the last one is row 1, column 0.
      reset_dut();
      run_pixels(57, 1'b1, '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      checks++;
      errors++;
      $display("FAIL watchdog: time limit reached, pending results %0d", exp_q.size());
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
